// File: rtl/io_pkg.sv
// Shared constants, status record and status helpers for the KEY/SW input device.
package io_pkg;

    localparam int KEY_BITS = 4;
    localparam int SW_BITS  = 10;

    localparam logic [31:0] ADDR_KDATA = 32'hFFFFF080;
    localparam logic [31:0] ADDR_KCTRL = 32'hFFFFF084;
    localparam logic [31:0] ADDR_SDATA = 32'hFFFFF090;
    localparam logic [31:0] ADDR_SCTRL = 32'hFFFFF094;

    localparam int CTRL_READY   = 0;
    localparam int CTRL_OVERRUN = 2;
    localparam int CTRL_IE      = 8;

    typedef struct packed {
        logic ie;
        logic overrun;
        logic ready;
    } status_t;

    // A fresh commit always wins: it sets READY and, if the previous value was never read, OVERRUN.
    function automatic status_t nextStatus(input status_t cur, input logic commit,
                                           input logic dataRead, input logic ctrlWrite,
                                           input logic clrOverrun, input logic ieEn,
                                           input logic ieVal);
        status_t nxt;
        nxt = cur;
        if (ctrlWrite && clrOverrun)
            nxt.overrun = 1'b0;
        if (ctrlWrite && ieEn)
            nxt.ie = ieVal;
        if (commit) begin
            nxt.ready = 1'b1;
            if (cur.ready && !dataRead)
                nxt.overrun = 1'b1;
        end else if (dataRead) begin
            nxt.ready = 1'b0;
        end
        return nxt;
    endfunction

    function automatic logic [31:0] statusWord(input status_t s);
        logic [31:0] w;
        w               = '0;
        w[CTRL_READY]   = s.ready;
        w[CTRL_OVERRUN] = s.overrun;
        w[CTRL_IE]      = s.ie;
        return w;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus stability counter; flags a commit when a stable value differs from the current one.
// CYCLES of 1 bypasses the counter so the synchronised value commits directly.
module io_debounce #(
    parameter int                WIDTH     = 10,
    parameter int                CYCLES    = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_raw,
    input  logic [WIDTH-1:0] i_current,
    output logic [WIDTH-1:0] o_value,
    output logic             o_commit
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (CYCLES <= 1) begin : g_bypass
            assign o_value  = r_sync2;
            assign o_commit = (r_sync2 != i_current);
        end else begin : g_count
            localparam int              CW   = $clog2(CYCLES);
            localparam logic [CW-1:0]   LAST = CW'(CYCLES - 1);

            logic [WIDTH-1:0] r_cand;
            logic [CW-1:0]    r_cnt;

            // Any disagreement restarts the window; the count saturates once the window is full.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cand <= RESET_VAL;
                    r_cnt  <= '0;
                end else if (r_sync2 != r_cand) begin
                    r_cand <= r_sync2;
                    r_cnt  <= '0;
                end else if (r_cnt != LAST) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign o_value  = r_cand;
            assign o_commit = (r_cnt == LAST) && (r_cand != i_current);
        end
    endgenerate

endmodule

// File: rtl/io_keysw_ctrl.sv
// Memory-mapped KEY/SW input device read by the MEM stage: synchronised keys, debounced switches, READY/OVERRUN status.
// Define IO_IRQ_EN to add the per-channel IE bits and the registered irq output.
module io_keysw_ctrl
    import io_pkg::*;
#(
    parameter int               DBITS           = 32,
    parameter int               KEYBITS         = KEY_BITS,
    parameter int               SWBITS          = SW_BITS,
    parameter int               DEBOUNCE_CYCLES = 100000,
    parameter logic [DBITS-1:0] ADDRKDATA       = ADDR_KDATA,
    parameter logic [DBITS-1:0] ADDRKCTRL       = ADDR_KCTRL,
    parameter logic [DBITS-1:0] ADDRSDATA       = ADDR_SDATA,
    parameter logic [DBITS-1:0] ADDRSCTRL       = ADDR_SCTRL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KEYBITS-1:0] KEY,
    input  logic [SWBITS-1:0]  SW,
    input  logic [DBITS-1:0]   abus,
    input  logic               re,
    input  logic               we,
    input  logic [DBITS-1:0]   wdata,
    output logic [DBITS-1:0]   rdata,
    output logic               hit
`ifdef IO_IRQ_EN
    ,
    output logic               irq
`endif
);

    logic [KEYBITS-1:0] r_kdata;
    logic [SWBITS-1:0]  r_sdata;
    status_t            r_kStat;
    status_t            r_sStat;

    logic [KEYBITS-1:0] w_keySync;
    logic [KEYBITS-1:0] w_kval;
    logic [SWBITS-1:0]  w_swCand;
    logic               w_kCommit;
    logic               w_sCommit;
    logic               w_selKData;
    logic               w_selKCtrl;
    logic               w_selSData;
    logic               w_selSCtrl;
    logic               w_kDataRead;
    logic               w_sDataRead;
    logic               w_kCtrlWrite;
    logic               w_sCtrlWrite;
    logic               w_ieEn;
    logic               w_unusedBits;

    // Keys are active-low, so the synchroniser idles at all-ones and compares against the inverted data.
    io_debounce #(
        .WIDTH     (KEYBITS),
        .CYCLES    (1),
        .RESET_VAL ({KEYBITS{1'b1}})
    ) u_keyDebounce (
        .clk       (clk),
        .reset     (reset),
        .i_raw     (KEY),
        .i_current (~r_kdata),
        .o_value   (w_keySync),
        .o_commit  (w_kCommit)
    );

    assign w_kval = ~w_keySync;

    io_debounce #(
        .WIDTH     (SWBITS),
        .CYCLES    (DEBOUNCE_CYCLES),
        .RESET_VAL ('0)
    ) u_swDebounce (
        .clk       (clk),
        .reset     (reset),
        .i_raw     (SW),
        .i_current (r_sdata),
        .o_value   (w_swCand),
        .o_commit  (w_sCommit)
    );

    assign w_selKData = (abus == ADDRKDATA);
    assign w_selKCtrl = (abus == ADDRKCTRL);
    assign w_selSData = (abus == ADDRSDATA);
    assign w_selSCtrl = (abus == ADDRSCTRL);
    assign hit        = w_selKData | w_selKCtrl | w_selSData | w_selSCtrl;

    // A simultaneous read and write strobe behaves as a write only.
    assign w_kDataRead  = re && !we && w_selKData;
    assign w_sDataRead  = re && !we && w_selSData;
    assign w_kCtrlWrite = we && w_selKCtrl;
    assign w_sCtrlWrite = we && w_selSCtrl;

`ifdef IO_IRQ_EN
    assign w_ieEn = 1'b1;
`else
    assign w_ieEn = 1'b0;
`endif

    assign w_unusedBits = ^{wdata[DBITS-1:CTRL_IE+1], wdata[CTRL_IE-1:CTRL_OVERRUN+1],
                            wdata[CTRL_OVERRUN-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kdata <= '0;
            r_sdata <= '0;
            r_kStat <= '0;
            r_sStat <= '0;
        end else begin
            if (w_kCommit)
                r_kdata <= w_kval;
            if (w_sCommit)
                r_sdata <= w_swCand;
            r_kStat <= nextStatus(r_kStat, w_kCommit, w_kDataRead, w_kCtrlWrite,
                                  !wdata[CTRL_OVERRUN], w_ieEn, wdata[CTRL_IE]);
            r_sStat <= nextStatus(r_sStat, w_sCommit, w_sDataRead, w_sCtrlWrite,
                                  !wdata[CTRL_OVERRUN], w_ieEn, wdata[CTRL_IE]);
        end
    end

`ifdef IO_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_irq <= 1'b0;
        else
            r_irq <= (r_kStat.ready & r_kStat.ie) | (r_sStat.ready & r_sStat.ie);
    end

    assign irq = r_irq;
`endif

    always_comb begin
        rdata = '0;
        if (w_selKData)
            rdata = DBITS'(r_kdata);
        else if (w_selKCtrl)
            rdata = DBITS'(statusWord(r_kStat));
        else if (w_selSData)
            rdata = DBITS'(r_sdata);
        else if (w_selSCtrl)
            rdata = DBITS'(statusWord(r_sStat));
    end

endmodule
